// File: rtl/uart_rx_ctrl_fsm.sv
// uart_rx_ctrl_fsm: UART receive sequencer with 3-point majority oversampling and frame checks.
// Define UART_RX_BREAK_DETECT_EN to add rx_break and the post-break idle qualification.
module uart_rx_ctrl_fsm #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      par_en,
    input  logic                      par_typ,
    input  logic [PRESCALE_WIDTH-1:0] edge_count,
    input  logic [BIT_CNT_WIDTH-1:0]  bit_count,
    output logic                      cnt_enable,
    output logic                      disable_bit_count,
    output logic [DATA_WIDTH-1:0]     p_data,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stop_err,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                      rx_break,
`endif
    output logic                      busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);
    state_t state, next_state;
    logic [PRESCALE_WIDTH-1:0] mid, prescale_q;
    logic [DATA_WIDTH-1:0] shift;
    logic s0, s1, s2, s2_eff, maj, bit_end, legal, abort, go, last_bit;
    logic par_en_q, par_typ_q;
    assign mid = prescale >> 1;
    assign bit_end = edge_count == prescale - ONE;
    assign legal = prescale inside {PRESCALE_WIDTH'(4), PRESCALE_WIDTH'(8), PRESCALE_WIDTH'(16), PRESCALE_WIDTH'(32)};
    assign busy = state != IDLE;
    assign abort = busy && prescale != prescale_q;
    assign last_bit = state == STOP && bit_end;
    assign cnt_enable = busy && !last_bit;
    assign disable_bit_count = !cnt_enable;
    // At prescale 4 the third sample coincides with bit end, so bypass its register.
    assign s2_eff = edge_count == mid + ONE ? rx_in : s2;
    assign maj = (s0 & s1) | (s0 & s2_eff) | (s1 & s2_eff);
`ifdef UART_RX_BREAK_DETECT_EN
    logic brk_hold, all_zero;
    logic [PRESCALE_WIDTH-1:0] high_cnt;
    assign go = legal && !rx_in && !brk_hold;
`else
    assign go = legal && !rx_in;
`endif
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = go ? START : IDLE;
            START:   next_state = bit_end ? (maj ? IDLE : DATA) : START;
            DATA:    next_state = bit_end && bit_count == BIT_CNT_WIDTH'(DATA_WIDTH) ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  next_state = bit_end ? STOP : PARITY;
            STOP:    next_state = bit_end ? IDLE : STOP;
            default: next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {s0, s1, s2} <= 3'b000;
        end else if (busy) begin
            if (edge_count == mid - ONE) s0 <= rx_in;
            if (edge_count == mid) s1 <= rx_in;
            if (edge_count == mid + ONE) s2 <= rx_in;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            p_data <= '0;
            shift <= '0;
            data_valid <= 1'b0;
            par_err <= 1'b0;
            stop_err <= 1'b0;
            par_en_q <= 1'b0;
            par_typ_q <= 1'b0;
            prescale_q <= '0;
        end else begin
            data_valid <= 1'b0;
            if (state == IDLE && go) begin
                par_err <= 1'b0;
                stop_err <= 1'b0;
                shift <= '0;
                par_en_q <= par_en;
                par_typ_q <= par_typ;
                prescale_q <= prescale;
            end
            if (!abort && bit_end) begin
                if (state == DATA) shift <= {maj, shift[DATA_WIDTH-1:1]};
                if (state == PARITY) par_err <= maj != (^shift ^ par_typ_q);
                if (state == STOP) begin
                    stop_err <= !maj;
                    if (!par_err && maj) begin
                        p_data <= shift;
                        data_valid <= 1'b1;
                    end
                end
            end
        end
    end
`ifdef UART_RX_BREAK_DETECT_EN
    // A break keeps new starts blocked until the line has idled high for a full bit time.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_break <= 1'b0;
            brk_hold <= 1'b0;
            all_zero <= 1'b0;
            high_cnt <= '0;
        end else begin
            rx_break <= 1'b0;
            if (state == IDLE && go) all_zero <= 1'b1;
            if (!abort && bit_end && (state == DATA || state == PARITY)) all_zero <= all_zero & !maj;
            if (!abort && last_bit && all_zero && !maj) begin
                rx_break <= 1'b1;
                brk_hold <= 1'b1;
                high_cnt <= '0;
            end
            if (state == IDLE && brk_hold) begin
                high_cnt <= rx_in ? high_cnt + ONE : '0;
                if (rx_in && high_cnt == prescale - ONE) brk_hold <= 1'b0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_uart_rx_ctrl_fsm.sv
// tb_uart_rx_ctrl_fsm: scoreboard bench for uart_rx_ctrl_fsm with a behavioural edge/bit counter.
module tb_uart_rx_ctrl_fsm;
    logic clk = 1'b0;
    logic rst, rx_in, par_en, par_typ;
    logic [5:0] prescale, edge_count, bit_count6;
    logic [3:0] bit_count;
    logic cnt_enable, disable_bit_count, data_valid, par_err, stop_err, busy;
    logic [7:0] p_data;
    int checks = 0;
    int failures = 0;
    int dv_count = 0;
    logic dv_prev = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_ctrl_fsm dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
        .par_en(par_en), .par_typ(par_typ), .edge_count(edge_count), .bit_count(bit_count),
        .cnt_enable(cnt_enable), .disable_bit_count(disable_bit_count), .p_data(p_data),
        .data_valid(data_valid), .par_err(par_err), .stop_err(stop_err), .busy(busy)
    );

    // Edge/bit counter as it sits beside the FSM: cleared whenever not enabled.
    always @(posedge clk) begin
        if (rst || disable_bit_count || !cnt_enable) begin
            edge_count <= '0;
            bit_count6 <= '0;
        end else if (edge_count == prescale - 6'd1) begin
            edge_count <= '0;
            bit_count6 <= bit_count6 + 6'd1;
        end else begin
            edge_count <= edge_count + 6'd1;
        end
    end
    assign bit_count = bit_count6[3:0];

    always @(negedge clk) begin
        if (!rst && data_valid) begin
            logic [7:0] e;
            dv_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid p_data=%h", p_data);
            end else begin
                e = exp_q.pop_front();
                if (p_data !== e) begin
                    failures++;
                    $display("FAIL p_data got=%h exp=%h", p_data, e);
                end
            end
            checks++;
            if (dv_prev) begin
                failures++;
                $display("FAIL valid_width got=2+ cycles exp=1");
            end
        end
        dv_prev = data_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit use_par, input bit pbit, input bit sbit, input int ps);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            tick(ps);
        end
        if (use_par) begin
            rx_in = pbit;
            tick(ps);
        end
        rx_in = sbit;
        tick(ps);
        rx_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit use_par, input bit pbit, input bit sbit, input int ps);
        rx_in = 1'b0;
        tick(ps);
        send_bits(b, use_par, pbit, sbit, ps);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s pending got=%0d exp=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string name, input logic [7:0] exp_data);
        checks++;
        if ({cnt_enable, disable_bit_count, data_valid, par_err, stop_err, busy, p_data} !== {6'b010000, exp_data}) begin
            failures++;
            $display("FAIL %s got=%b_%h exp=010000_%h", name,
                     {cnt_enable, disable_bit_count, data_valid, par_err, stop_err, busy}, p_data, exp_data);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        check_idle_outputs("reset_held", 8'h00);
        rst = 1'b0;
        tick(3);
        check_idle_outputs("reset_released", 8'h00);
    endtask

    task automatic test_basic;
        prescale = 6'd8;
        par_en = 1'b0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8);
        tick(8);
        check_drained("basic_a5");
        check_idle_outputs("basic_after", 8'hA5);
    endtask

    task automatic test_parity;
        int dv0;
        prescale = 6'd16;
        par_en = 1'b1;
        par_typ = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16);
        tick(16);
        check_drained("parity_good");
        dv0 = dv_count;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
        tick(16);
        checks++;
        if (par_err !== 1'b1 || stop_err !== 1'b0 || p_data !== 8'h3C || dv_count != dv0) begin
            failures++;
            $display("FAIL parity_bad got=%b%b_%h_%0d exp=10_3c_%0d", par_err, stop_err, p_data, dv_count, dv0);
        end
        par_typ = 1'b1;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
        tick(16);
        check_drained("parity_odd");
        checks++;
        if (par_err !== 1'b0) begin
            failures++;
            $display("FAIL parity_odd_err got=%b exp=0", par_err);
        end
        par_en = 1'b0;
        par_typ = 1'b0;
    endtask

    task automatic test_stop_err;
        int dv0;
        prescale = 6'd4;
        dv0 = dv_count;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 4);
        tick(4);
        checks++;
        if (stop_err !== 1'b1 || par_err !== 1'b0 || dv_count != dv0) begin
            failures++;
            $display("FAIL stop_err got=%b%b_%0d exp=10_%0d", stop_err, par_err, dv_count, dv0);
        end
        exp_q.push_back(8'h12);
        rx_in = 1'b0;
        tick(2);
        checks++;
        if (stop_err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL flag_clear got=%b%b exp=01", stop_err, busy);
        end
        tick(2);
        send_bits(8'h12, 1'b0, 1'b0, 1'b1, 4);
        tick(4);
        check_drained("after_stop_err");
    endtask

    task automatic test_glitch;
        int dv0;
        prescale = 6'd32;
        dv0 = dv_count;
        rx_in = 1'b0;
        tick(2);
        rx_in = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_start got=%b exp=1", busy);
        end
        tick(40);
        checks++;
        if (busy !== 1'b0 || par_err !== 1'b0 || stop_err !== 1'b0 || dv_count != dv0) begin
            failures++;
            $display("FAIL glitch got=%b%b%b_%0d exp=000_%0d", busy, par_err, stop_err, dv_count, dv0);
        end
    endtask

    task automatic test_back_to_back;
        int dv0;
        prescale = 6'd8;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 8);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 8);
        tick(8);
        check_drained("back_to_back");
        dv0 = dv_count;
        rx_in = 1'b0;
        tick(8);
        rx_in = 1'b1;
        tick(8);
        rx_in = 1'b0;
        tick(8);
        prescale = 6'd16;
        rx_in = 1'b1;
        tick(1);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy got=%b exp=0", busy);
        end
        tick(40);
        checks++;
        if (par_err !== 1'b0 || stop_err !== 1'b0 || dv_count != dv0 || p_data !== 8'hAA) begin
            failures++;
            $display("FAIL abort got=%b%b_%0d_%h exp=00_%0d_aa", par_err, stop_err, dv_count, p_data, dv0);
        end
        prescale = 6'd8;
        tick(2);
    endtask

    task automatic test_reset_mid_frame;
        prescale = 6'd8;
        rx_in = 1'b0;
        tick(8);
        for (int i = 0; i < 4; i++) tick(8);
        rx_in = 1'b1;
        tick(3);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_frame_busy got=%b exp=1", busy);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_idle_outputs("reset_mid_frame", 8'h00);
        tick(10);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 8);
        tick(8);
        check_drained("after_reset_81");
    endtask

    initial begin
        rst = 1'b1;
        rx_in = 1'b1;
        prescale = 6'd8;
        par_en = 1'b0;
        par_typ = 1'b0;
        test_reset;
        test_basic;
        test_parity;
        test_stop_err;
        test_glitch;
        test_back_to_back;
        test_reset_mid_frame;
        tick(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl_fsm.md
Name: uart_rx_ctrl_fsm

Overview:
- Receive-side sequencer for the UART RX path.
- Drives the edge/bit counter (enable, bit-count clear) and oversamples rx_in with 3-point majority voting.
- Walks the frame: start, 8 data bits LSB-first, optional parity, stop. Checks start glitch, parity and stop, then delivers a parallel byte with a one-cycle valid strobe.
- Sits between the RX pin synchroniser and the register-file/FIFO write side.

Parameters:
- PRESCALE_WIDTH, 6, width of prescale and edge_count.
- BIT_CNT_WIDTH, 4, width of bit_count from the counter.
- DATA_WIDTH, 8, payload bits per frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_in  in  1  synchronised serial input; idle high.
- prescale  in  PRESCALE_WIDTH  oversampling ratio; legal values 4, 8, 16, 32.
- par_en  in  1  parity bit present.
- par_typ  in  1  0 = even, 1 = odd.
- edge_count  in  PRESCALE_WIDTH  oversample edge index within the current bit.
- bit_count  in  BIT_CNT_WIDTH  bit index within the frame.
- cnt_enable  out  1  drives the counter enable.
- disable_bit_count  out  1  clears/holds the counter bit_count.
- p_data  out  DATA_WIDTH  received byte.
- data_valid  out  1  one-cycle strobe: p_data is new.
- par_err  out  1  parity error, held until next frame start.
- stop_err  out  1  framing error, held until next frame start.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - State = IDLE.
  - cnt_enable=0, disable_bit_count=1, data_valid=0, par_err=0, stop_err=0, busy=0.
  - p_data=0; shift register = 0.
- Sampling:
  - Let M = prescale>>1.
  - Sample rx_in at edge_count == M-1, M and M+1. The bit value is the majority of the three samples.
  - Bit end is edge_count == prescale-1. The counter increments bit_count at that cycle.
- States:
  - IDLE: cnt_enable=0, disable_bit_count=1. If rx_in==0 and prescale is legal, go to START next cycle. In START, cnt_enable=1 and disable_bit_count=0. Clear par_err and stop_err on this transition.
  - START: at bit end, majority==1 means a glitch: go to IDLE with no flags set. Otherwise go to DATA.
  - DATA: at each bit end, shift the majority bit in LSB-first. After the bit end with bit_count==DATA_WIDTH, go to PARITY if par_en=1, else STOP.
  - PARITY: at bit end, expected parity = XOR of the data bits, inverted when par_typ=1. par_err=1 on mismatch. Go to STOP.
  - STOP: at bit end, stop_err=1 if majority==0. Go to IDLE. Same cycle: disable_bit_count=1 and cnt_enable=0.
- Output update on STOP exit:
  - If par_err==0 and stop_err==0: p_data <= shift register and data_valid=1 for exactly that one cycle.
  - If either error is set: p_data keeps its old value and data_valid stays 0.
- Back-to-back frames: from IDLE, a low rx_in on the first cycle after STOP exit starts the next frame. No extra idle cycle is required.
- Abort conditions:
  - prescale changes while busy: return to IDLE next cycle, set no flags, raise no data_valid.
  - prescale illegal in IDLE: stay in IDLE.
- par_en and par_typ are captured at START entry. Changes mid-frame have no effect on the current frame.
- rst asserted mid-frame: state returns to IDLE at that clock edge, all outputs take reset values, and the partial byte is discarded.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- When defined: adds output rx_break (1 bit).
  - Set for one cycle on STOP exit when all data bits, the parity bit (if present) and the stop bit sampled 0.
  - stop_err is also set; data_valid stays 0.
  - The FSM then waits in IDLE until rx_in has been 1 for at least prescale consecutive cycles before it accepts a new start.
- When undefined: no rx_break port. A break is reported only as stop_err=1, and the next start is accepted immediately.

Test Plan:
- prescale=8, par_en=0, serial 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> one data_valid pulse, p_data=0xA5, par_err=0, stop_err=0, busy low afterwards.
- prescale=16, par_en=1, par_typ=0, byte 0x3C with correct even parity bit 0 -> p_data=0x3C, data_valid pulse. Repeat with parity bit 1 -> par_err=1, no data_valid, p_data unchanged.
- prescale=4, byte 0xFF with stop bit 0 -> stop_err=1, no data_valid. A following valid frame 0x12 -> flags clear at START, p_data=0x12.
- rx_in low for only 2 cycles at prescale=32 (majority at mid-bit = 1) -> return to IDLE, no flags, no data_valid.
- Two frames, 0x55 then 0xAA, back-to-back at prescale=8 -> two data_valid pulses with the correct bytes. Change prescale 8->16 mid-frame -> abort to IDLE, no output.
- rst pulsed high during DATA at bit 4 -> next cycle all outputs at reset values. A subsequent 0x81 frame is received correctly.
